// File: rtl/zion_riscv_isa_lib_add_sub_de_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | zion_riscv_isa_lib_add_sub_pkg: opcode/funct constants, op bit indices,  |
// | and the decode-stage buffer state encoding.                              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package zion_riscv_isa_lib_add_sub_pkg;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_BLT     = 3'b100;
  localparam logic [2:0] F3_BGE     = 3'b101;
  localparam logic [2:0] F3_BLTU    = 3'b110;
  localparam logic [2:0] F3_BGEU    = 3'b111;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  localparam int ADD_BIT = 0;
  localparam int SUB_BIT = 1;
  localparam int W_BIT   = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } buf_state_e;

endpackage
`default_nettype wire

// File: rtl/zion_riscv_isa_lib_add_sub_de_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | zion_riscv_isa_lib_add_sub_de_if: upstream and execute-side handshake    |
// | bundle; names are from the decode stage's point of view.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface zion_riscv_isa_lib_add_sub_de_if #(
  parameter int RV64 = 0
);
  localparam int CPU_WIDTH = 32 * (RV64 + 1);

  logic                 i_vld;
  logic                 o_rdy;
  logic [31:0]          i_instr;
  logic [CPU_WIDTH-1:0] i_rs1;
  logic [CPU_WIDTH-1:0] i_rs2;
  logic                 o_vld;
  logic                 i_rdy;
  logic [RV64+1:0]      o_op;
  logic [CPU_WIDTH-1:0] o_s1;
  logic [CPU_WIDTH-1:0] o_s2;
  logic                 o_unsigned;
  logic                 o_hit;

  modport slave (
    input  i_vld, i_instr, i_rs1, i_rs2, i_rdy,
    output o_rdy, o_vld, o_op, o_s1, o_s2, o_unsigned, o_hit
  );

  modport master (
    output i_vld, i_instr, i_rs1, i_rs2, i_rdy,
    input  o_rdy, o_vld, o_op, o_s1, o_s2, o_unsigned, o_hit
  );

endinterface
`default_nettype wire

// File: rtl/zion_riscv_isa_lib_add_sub_de_dec_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | zion_riscv_isa_lib_add_sub_dec_core: combinational decode of adder users |
// | into op/s1/s2/unsigned/hit.                                              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module zion_riscv_isa_lib_add_sub_dec_core
  import zion_riscv_isa_lib_add_sub_pkg::*;
#(
  parameter int RV64 = 0
) (
  input  logic [31:0]            i_instr,
  input  logic [32*(RV64+1)-1:0] i_rs1,
  input  logic [32*(RV64+1)-1:0] i_rs2,
  output logic [RV64+1:0]        o_op,
  output logic [32*(RV64+1)-1:0] o_s1,
  output logic [32*(RV64+1)-1:0] o_s2,
  output logic                   o_unsigned,
  output logic                   o_hit
);
  localparam int CPU_WIDTH = 32 * (RV64 + 1);

  logic [6:0]           w_opc;
  logic [2:0]           w_f3;
  logic [6:0]           w_f7;
  logic [CPU_WIDTH-1:0] w_imm_i;
  logic [CPU_WIDTH-1:0] w_imm_s;
  logic                 w_add;
  logic                 w_sub;
  logic                 w_w;
  logic                 w_uns;
  logic                 w_sel_i;
  logic                 w_sel_s;
  logic                 w_unused;

  assign w_opc    = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_f7     = i_instr[31:25];
  assign w_imm_i  = {{(CPU_WIDTH-12){i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s  = {{(CPU_WIDTH-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  // Register-number fields are resolved upstream; only the immediate bits matter here.
  assign w_unused = ^{i_instr[19:15], w_w};

  always_comb begin
    w_add   = 1'b0;
    w_sub   = 1'b0;
    w_w     = 1'b0;
    w_uns   = 1'b0;
    w_sel_i = 1'b0;
    w_sel_s = 1'b0;
    case (w_opc)
      OPC_OP: begin
        if (w_f3 == F3_ADD_SUB) begin
          w_add = (w_f7 == F7_ADD);
          w_sub = (w_f7 == F7_SUB);
        end else if (w_f3 == F3_SLT || w_f3 == F3_SLTU) begin
          w_sub = 1'b1;
          w_uns = (w_f3 == F3_SLTU);
        end
      end
      OPC_OP_IMM: begin
        w_sel_i = 1'b1;
        if (w_f3 == F3_ADD_SUB) begin
          w_add = 1'b1;
        end else if (w_f3 == F3_SLT || w_f3 == F3_SLTU) begin
          w_sub = 1'b1;
          w_uns = (w_f3 == F3_SLTU);
        end
      end
      // BLT/BGE/BLTU/BGEU share f3[2]=1; BEQ/BNE use the equality path instead.
      OPC_BRANCH: begin
        if (w_f3[2]) begin
          w_sub = 1'b1;
          w_uns = w_f3[1];
        end
      end
      OPC_LOAD: begin
        w_add   = 1'b1;
        w_sel_i = 1'b1;
      end
      OPC_STORE: begin
        w_add   = 1'b1;
        w_sel_s = 1'b1;
      end
      OPC_OP_32: begin
        if (RV64 != 0 && w_f3 == F3_ADD_SUB) begin
          w_add = (w_f7 == F7_ADD);
          w_sub = (w_f7 == F7_SUB);
          w_w   = (w_f7 == F7_ADD) || (w_f7 == F7_SUB);
        end
      end
      OPC_OP_IMM_32: begin
        if (RV64 != 0 && w_f3 == F3_ADD_SUB) begin
          w_add   = 1'b1;
          w_w     = 1'b1;
          w_sel_i = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign o_hit      = w_add | w_sub;
  assign o_unsigned = w_uns;
  assign o_s1       = i_rs1;
  assign o_s2       = (o_hit && w_sel_i) ? w_imm_i :
                      (o_hit && w_sel_s) ? w_imm_s : i_rs2;

  generate
    if (RV64 != 0) begin : g_op_rv64
      always_comb begin
        o_op          = '0;
        o_op[ADD_BIT] = w_add;
        o_op[SUB_BIT] = w_sub;
        o_op[W_BIT]   = w_w;
      end
    end else begin : g_op_rv32
      always_comb begin
        o_op          = '0;
        o_op[ADD_BIT] = w_add;
        o_op[SUB_BIT] = w_sub;
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/zion_riscv_isa_lib_add_sub_de.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | zion_riscv_isa_lib_add_sub_de: registered add/sub decode stage with a    |
// | valid/ready buffer; ZION_RISCV_ISA_LIB_ADD_SUB_DE_SKID_EN adds skid.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module zion_riscv_isa_lib_add_sub_de
  import zion_riscv_isa_lib_add_sub_pkg::*;
#(
  parameter int RV64 = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  zion_riscv_isa_lib_add_sub_de_if.slave  io
);
  localparam int CPU_WIDTH = 32 * (RV64 + 1);
  localparam int OP_W      = RV64 + 2;
  localparam int BW        = OP_W + 2 * CPU_WIDTH + 2;

  logic [OP_W-1:0]      w_dec_op;
  logic [CPU_WIDTH-1:0] w_dec_s1;
  logic [CPU_WIDTH-1:0] w_dec_s2;
  logic                 w_dec_uns;
  logic                 w_dec_hit;
  logic [BW-1:0]        w_dec;
  logic [BW-1:0]        r_out;
  buf_state_e           r_state;
  buf_state_e           w_state_nxt;
  logic                 w_vld;
  logic                 w_rdy;
  logic                 w_in_xfer;
  logic                 w_out_xfer;
  logic                 w_load_out;
`ifdef ZION_RISCV_ISA_LIB_ADD_SUB_DE_SKID_EN
  logic [BW-1:0]        r_skd;
  logic                 r_rdy;
  logic                 w_load_skd;
  logic                 w_pop_skd;
`endif

  zion_riscv_isa_lib_add_sub_dec_core #(
    .RV64 (RV64)
  ) u_dec (
    .i_instr    (io.i_instr),
    .i_rs1      (io.i_rs1),
    .i_rs2      (io.i_rs2),
    .o_op       (w_dec_op),
    .o_s1       (w_dec_s1),
    .o_s2       (w_dec_s2),
    .o_unsigned (w_dec_uns),
    .o_hit      (w_dec_hit)
  );

  assign w_dec      = {w_dec_op, w_dec_s1, w_dec_s2, w_dec_uns, w_dec_hit};
  assign w_vld      = (r_state != ST_EMPTY);
  assign w_in_xfer  = io.i_vld & w_rdy;
  assign w_out_xfer = w_vld & io.i_rdy;

  assign io.o_vld = w_vld;
  assign io.o_rdy = w_rdy;
  assign {io.o_op, io.o_s1, io.o_s2, io.o_unsigned, io.o_hit} = r_out;

  always_comb begin
    w_state_nxt = r_state;
    w_load_out  = 1'b0;
`ifdef ZION_RISCV_ISA_LIB_ADD_SUB_DE_SKID_EN
    w_load_skd  = 1'b0;
    w_pop_skd   = 1'b0;
`endif
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt = ST_FULL;
          w_load_out  = 1'b1;
        end
      end
      ST_FULL: begin
        if (w_in_xfer && w_out_xfer) begin
          w_load_out = 1'b1;
        end else if (w_out_xfer) begin
          w_state_nxt = ST_EMPTY;
`ifdef ZION_RISCV_ISA_LIB_ADD_SUB_DE_SKID_EN
        end else if (w_in_xfer) begin
          w_state_nxt = ST_SKID;
          w_load_skd  = 1'b1;
`endif
        end
      end
`ifdef ZION_RISCV_ISA_LIB_ADD_SUB_DE_SKID_EN
      ST_SKID: begin
        if (w_out_xfer) begin
          w_state_nxt = ST_FULL;
          w_pop_skd   = 1'b1;
        end
      end
`endif
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
    end else if (w_load_out) begin
      r_out <= w_dec;
`ifdef ZION_RISCV_ISA_LIB_ADD_SUB_DE_SKID_EN
    end else if (w_pop_skd) begin
      r_out <= r_skd;
`endif
    end
  end

`ifdef ZION_RISCV_ISA_LIB_ADD_SUB_DE_SKID_EN
  // r_rdy tracks "next state is not SKID", so o_rdy never sees i_rdy combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_skd <= '0;
      r_rdy <= 1'b1;
    end else begin
      if (w_load_skd) begin
        r_skd <= w_dec;
      end
      r_rdy <= (w_state_nxt != ST_SKID);
    end
  end

  assign w_rdy = r_rdy & ~rst;
`else
  assign w_rdy = ~rst & (~w_vld | io.i_rdy);
`endif

endmodule
`default_nettype wire

// File: tb/tb_zion_riscv_isa_lib_add_sub_de.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for zion_riscv_isa_lib_add_sub_de: RV32 and RV64 instances share stimulus
// and are checked against a spec-level decode model and per-instance scoreboards.
module tb_zion_riscv_isa_lib_add_sub_de;

  typedef struct packed {
    logic [2:0]  op;
    logic [63:0] s1;
    logic [63:0] s2;
    logic        uns;
    logic        hit;
  } bndl_t;

`ifdef ZION_RISCV_ISA_LIB_ADD_SUB_DE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  zion_riscv_isa_lib_add_sub_de_if #(.RV64(0)) b32 ();
  zion_riscv_isa_lib_add_sub_de_if #(.RV64(1)) b64 ();

  zion_riscv_isa_lib_add_sub_de #(.RV64(0)) u_dut32 (.clk(clk), .rst(rst), .io(b32));
  zion_riscv_isa_lib_add_sub_de #(.RV64(1)) u_dut64 (.clk(clk), .rst(rst), .io(b64));

  function automatic bndl_t obs32();
    return {1'b0, b32.o_op, 32'd0, b32.o_s1, 32'd0, b32.o_s2, b32.o_unsigned, b32.o_hit};
  endfunction

  function automatic bndl_t obs64();
    return {b64.o_op, b64.o_s1, b64.o_s2, b64.o_unsigned, b64.o_hit};
  endfunction

  // Mnemonic-level classification of which instructions use the adder.
  function automatic bndl_t ref_model(input logic [31:0] ins, input logic [63:0] a,
                                      input logic [63:0] b, input bit rv64);
    bndl_t       e;
    logic [6:0]  opc = ins[6:0];
    logic [2:0]  f3  = ins[14:12];
    logic [6:0]  f7  = ins[31:25];
    logic [63:0] imm_i = {{52{ins[31]}}, ins[31:20]};
    logic [63:0] imm_s = {{52{ins[31]}}, ins[31:25], ins[11:7]};
    bit is_add = 0, is_sub = 0, is_w = 0, uns = 0, use_i = 0, use_s = 0;
    case (opc)
      7'b0110011: begin
        if (f3 == 3'd0 && f7 == 7'h00) is_add = 1;
        else if (f3 == 3'd0 && f7 == 7'h20) is_sub = 1;
        else if (f3 == 3'd2 || f3 == 3'd3) begin is_sub = 1; uns = (f3 == 3'd3); end
      end
      7'b0010011: begin
        if (f3 == 3'd0) begin is_add = 1; use_i = 1; end
        else if (f3 == 3'd2 || f3 == 3'd3) begin is_sub = 1; use_i = 1; uns = (f3 == 3'd3); end
      end
      7'b1100011: if (f3 >= 3'd4) begin is_sub = 1; uns = (f3 >= 3'd6); end
      7'b0000011: begin is_add = 1; use_i = 1; end
      7'b0100011: begin is_add = 1; use_s = 1; end
      7'b0111011: if (rv64 && f3 == 3'd0 && (f7 == 7'h00 || f7 == 7'h20)) begin
        is_w = 1; is_add = (f7 == 7'h00); is_sub = (f7 == 7'h20);
      end
      7'b0011011: if (rv64 && f3 == 3'd0) begin is_w = 1; is_add = 1; use_i = 1; end
      default: ;
    endcase
    e.op  = {is_w, is_sub, is_add};
    e.hit = is_add | is_sub;
    e.uns = uns;
    e.s1  = a;
    e.s2  = use_i ? imm_i : (use_s ? imm_s : b);
    return e;
  endfunction

  function automatic bndl_t trunc32(input bndl_t e);
    bndl_t r = e;
    r.s1[63:32] = '0;
    r.s2[63:32] = '0;
    r.op[2]     = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [9] = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b0000011, 7'b0100011,
                              7'b0111011, 7'b0011011, 7'b0110111, 7'b1101111};
    logic [31:0] w = $urandom;
    w[6:0] = opcs[$urandom_range(8, 0)];
    case ($urandom_range(3, 0))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  task automatic drive(input logic vld, input logic [31:0] ins, input logic [63:0] a,
                       input logic [63:0] b, input logic rdy);
    b32.i_vld = vld; b32.i_instr = ins; b32.i_rs1 = a[31:0]; b32.i_rs2 = b[31:0]; b32.i_rdy = rdy;
    b64.i_vld = vld; b64.i_instr = ins; b64.i_rs1 = a;       b64.i_rs2 = b;       b64.i_rdy = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 32'h0020_81B3, 64'd1, 64'd2, 1'b0);
    step();
    step();
    n_tests++;
    if (b32.o_rdy !== 1'b0 || b64.o_rdy !== 1'b0) begin
      n_fail++; $display("FAIL reset_rdy: got %b/%b required 0/0", b32.o_rdy, b64.o_rdy);
    end
    n_tests++;
    if (b32.o_vld !== 1'b0 || obs32() !== '0) begin
      n_fail++; $display("FAIL reset_out32: vld=%b bundle=%h required all zero", b32.o_vld, obs32());
    end
    n_tests++;
    if (b64.o_vld !== 1'b0 || obs64() !== '0) begin
      n_fail++; $display("FAIL reset_out64: vld=%b bundle=%h required all zero", b64.o_vld, obs64());
    end
    rst = 1'b0;
    drive(1'b0, 32'd0, 64'd0, 64'd0, 1'b1);
    #1;
    n_tests++;
    if (b32.o_rdy !== 1'b1 || b64.o_rdy !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_rdy: got %b/%b required 1/1", b32.o_rdy, b64.o_rdy);
    end
    step();
    n_tests++;
    if (b32.o_vld !== 1'b0 || b64.o_vld !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_vld: got %b/%b required 0/0", b32.o_vld, b64.o_vld);
    end
  endtask

  task automatic test_add();
    bndl_t e = '{op: 3'b001, s1: 64'd5, s2: 64'd7, uns: 1'b0, hit: 1'b1};
    drive(1'b1, 32'h0020_81B3, 64'd5, 64'd7, 1'b1);
    step();
    n_tests++;
    if (b32.o_vld !== 1'b1 || obs32() !== e) begin
      n_fail++; $display("FAIL add32: vld=%b got %h required %h", b32.o_vld, obs32(), e);
    end
    n_tests++;
    if (b64.o_vld !== 1'b1 || obs64() !== e) begin
      n_fail++; $display("FAIL add64: vld=%b got %h required %h", b64.o_vld, obs64(), e);
    end
    drive(1'b0, 32'd0, 64'd0, 64'd0, 1'b1);
    step();
    n_tests++;
    if (b32.o_vld !== 1'b0 || b64.o_vld !== 1'b0) begin
      n_fail++; $display("FAIL add_drain: vld %b/%b required 0/0", b32.o_vld, b64.o_vld);
    end
  endtask

  task automatic test_bltu_lw();
    bndl_t e_b   = '{op: 3'b010, s1: 64'hFFFF_FFFF, s2: 64'd1, uns: 1'b1, hit: 1'b1};
    bndl_t e_l32 = '{op: 3'b001, s1: 64'h100, s2: 64'hFFFF_FFFC, uns: 1'b0, hit: 1'b1};
    bndl_t e_l64 = '{op: 3'b001, s1: 64'h100, s2: 64'hFFFF_FFFF_FFFF_FFFC, uns: 1'b0, hit: 1'b1};
    drive(1'b1, {7'd0, 5'd2, 5'd1, 3'b110, 5'd0, 7'b1100011}, 64'hFFFF_FFFF, 64'd1, 1'b1);
    step();
    n_tests++;
    if (obs32() !== e_b || obs64() !== e_b) begin
      n_fail++; $display("FAIL bltu: got %h/%h required %h", obs32(), obs64(), e_b);
    end
    drive(1'b1, {12'hFFC, 5'd1, 3'b010, 5'd5, 7'b0000011}, 64'h100, 64'h55, 1'b1);
    step();
    n_tests++;
    if (b32.o_vld !== 1'b1 || obs32() !== e_l32) begin
      n_fail++; $display("FAIL lw32: vld=%b got %h required %h", b32.o_vld, obs32(), e_l32);
    end
    n_tests++;
    if (b64.o_vld !== 1'b1 || obs64() !== e_l64) begin
      n_fail++; $display("FAIL lw64: vld=%b got %h required %h", b64.o_vld, obs64(), e_l64);
    end
    drive(1'b0, 32'd0, 64'd0, 64'd0, 1'b1);
    step();
  endtask

  task automatic test_addiw();
    bndl_t e64 = '{op: 3'b101, s1: 64'h10, s2: 64'd1,  uns: 1'b0, hit: 1'b1};
    bndl_t e32 = '{op: 3'b000, s1: 64'h10, s2: 64'h33, uns: 1'b0, hit: 1'b0};
    drive(1'b1, {12'd1, 5'd1, 3'b000, 5'd5, 7'b0011011}, 64'h10, 64'h33, 1'b1);
    step();
    n_tests++;
    if (obs64() !== e64) begin
      n_fail++; $display("FAIL addiw64: got %h required %h", obs64(), e64);
    end
    n_tests++;
    if (b32.o_vld !== 1'b1 || obs32() !== e32) begin
      n_fail++; $display("FAIL addiw32_nonhit: vld=%b got %h required %h", b32.o_vld, obs32(), e32);
    end
    drive(1'b0, 32'd0, 64'd0, 64'd0, 1'b1);
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins [3];
    logic [63:0] ra  [3];
    logic [63:0] rb  [3];
    bndl_t       q[$];
    bndl_t       e;
    int          sent = 0;
    int          got  = 0;
    int          k;
    logic        vld;
    logic        rdy;
    ins[0] = 32'h0020_81B3;
    ins[1] = 32'h4020_81B3;
    ins[2] = {12'hF80, 5'd1, 3'b011, 5'd4, 7'b0010011};
    for (int i = 0; i < 3; i++) begin
      ra[i] = {$urandom, $urandom};
      rb[i] = {$urandom, $urandom};
    end
    for (int cyc = 0; cyc < 16; cyc++) begin
      rdy = (cyc >= 5);
      vld = (sent < 3);
      k   = (sent < 3) ? sent : 2;
      drive(vld, ins[k], ra[k], rb[k], rdy);
      #1;
      if (cyc == 4) begin
        n_tests++;
        if (sent != CAP || b32.o_rdy !== 1'b0) begin
          n_fail++; $display("FAIL b2b_stall: accepted %0d rdy=%b required %0d rdy=0", sent, b32.o_rdy, CAP);
        end
      end
      if (b32.o_vld && rdy) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra: unexpected bundle %h required none", obs32());
        end else begin
          e = q.pop_front();
          got++;
          if (obs32() !== e) begin
            n_fail++; $display("FAIL b2b_order: got %h required %h", obs32(), e);
          end
        end
      end
      if (vld && b32.o_rdy) begin
        q.push_back(trunc32(ref_model(ins[k], {32'd0, ra[k][31:0]}, {32'd0, rb[k][31:0]}, 1'b0)));
        sent++;
      end
      step();
    end
    n_tests++;
    if (got != 3 || q.size() != 0) begin
      n_fail++; $display("FAIL b2b_count: delivered %0d left %0d required 3 and 0", got, q.size());
    end
  endtask

  task automatic test_rst_skid();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h0020_81B3, 64'd100 + 64'(i), 64'd9, 1'b0);
      step();
    end
    #1;
    n_tests++;
    if (b32.o_rdy !== 1'b0 || b32.o_vld !== 1'b1) begin
      n_fail++; $display("FAIL rst_fill: rdy=%b vld=%b required 0 and 1", b32.o_rdy, b32.o_vld);
    end
    rst = 1'b1;
    drive(1'b0, 32'd0, 64'd0, 64'd0, 1'b0);
    step();
    n_tests++;
    if (b32.o_vld !== 1'b0 || obs32() !== '0 || b32.o_rdy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid: vld=%b rdy=%b bundle=%h required 0 0 zero", b32.o_vld, b32.o_rdy, obs32());
    end
    rst = 1'b0;
    drive(1'b0, 32'd0, 64'd0, 64'd0, 1'b1);
    #1;
    n_tests++;
    if (b32.o_rdy !== 1'b1 || b64.o_rdy !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_rdy: got %b/%b required 1/1", b32.o_rdy, b64.o_rdy);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (b32.o_vld !== 1'b0 || b64.o_vld !== 1'b0) begin
        n_fail++; $display("FAIL rst_stale: vld %b/%b required 0/0", b32.o_vld, b64.o_vld);
      end
    end
  endtask

  task automatic test_random();
    bndl_t       q32[$];
    bndl_t       q64[$];
    bndl_t       hold32;
    bndl_t       hold64;
    bndl_t       e;
    bit          stall32 = 0;
    bit          stall64 = 0;
    logic        vld;
    logic        rdy;
    logic [31:0] ins;
    logic [63:0] a;
    logic [63:0] b;
    for (int cyc = 0; cyc < 700; cyc++) begin
      vld = (cyc < 690) && ($urandom_range(3, 0) != 0);
      rdy = (cyc >= 690) || ($urandom_range(2, 0) != 0);
      ins = rand_instr();
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      drive(vld, ins, a, b, rdy);
      #1;
      if (stall32) begin
        n_tests++;
        if (b32.o_vld !== 1'b1 || obs32() !== hold32) begin
          n_fail++; $display("FAIL rnd_hold32: got %h required %h", obs32(), hold32);
        end
      end
      if (stall64) begin
        n_tests++;
        if (b64.o_vld !== 1'b1 || obs64() !== hold64) begin
          n_fail++; $display("FAIL rnd_hold64: got %h required %h", obs64(), hold64);
        end
      end
      if (b32.o_vld) begin
        n_tests++;
        if (!$onehot0(b32.o_op[1:0])) begin
          n_fail++; $display("FAIL rnd_onehot32: op=%b required onehot0", b32.o_op);
        end
      end
      if (b64.o_vld) begin
        n_tests++;
        if (!$onehot0(b64.o_op[1:0])) begin
          n_fail++; $display("FAIL rnd_onehot64: op=%b required onehot0", b64.o_op);
        end
      end
      if (b32.o_vld && rdy) begin
        n_tests++;
        if (q32.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra32: got %h required none", obs32());
        end else begin
          e = q32.pop_front();
          if (obs32() !== e) begin
            n_fail++; $display("FAIL rnd_data32: got %h required %h", obs32(), e);
          end
        end
      end
      if (b64.o_vld && rdy) begin
        n_tests++;
        if (q64.size() == 0) begin
          n_fail++; $display("FAIL rnd_extra64: got %h required none", obs64());
        end else begin
          e = q64.pop_front();
          if (obs64() !== e) begin
            n_fail++; $display("FAIL rnd_data64: got %h required %h", obs64(), e);
          end
        end
      end
      if (vld && b32.o_rdy) q32.push_back(trunc32(ref_model(ins, {32'd0, a[31:0]}, {32'd0, b[31:0]}, 1'b0)));
      if (vld && b64.o_rdy) q64.push_back(ref_model(ins, a, b, 1'b1));
      stall32 = b32.o_vld && !rdy;
      stall64 = b64.o_vld && !rdy;
      hold32  = obs32();
      hold64  = obs64();
      step();
    end
    n_tests++;
    if (q32.size() != 0 || q64.size() != 0 || b32.o_vld !== 1'b0 || b64.o_vld !== 1'b0) begin
      n_fail++; $display("FAIL rnd_drain: left %0d/%0d vld %b/%b required 0/0 0/0",
                         q32.size(), q64.size(), b32.o_vld, b64.o_vld);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_bltu_lw();
    test_addiw();
    test_back_to_back();
    test_rst_skid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
